fnd_scan_ctrl: RTL and testbench

Time-multiplexing scheduler for the shared 4-digit seven-segment (FND) display. It owns the common segment bus and shares it among four 4-bit digit codes, such as the password and result digits produced by the password FSM. The block sequences digit-enable slots with anti-ghosting blank gaps, skips masked digits, and applies per-digit blinking. It sits between the password FSM outputs and the board FND pins.

---
 rtl/fnd_scan_if.sv | 25 ++
 rtl/fnd_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_if.sv
// Signal bundle between the password FSM side and the FND scan controller.
// master drives codes and masks; slave (the scanner) drives the FND pins.
interface fnd_scan_if;
  logic       en;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] dig_mask;
  logic [3:0] blink_mask;
  logic [3:0] com;
  logic [6:0] seg;
  logic [1:0] scan_idx;
  logic       frame_done;

  modport master (
    output en, digit0, digit1, digit2, digit3, dig_mask, blink_mask,
    input  com, seg, scan_idx, frame_done
  );

  modport slave (
    input  en, digit0, digit1, digit2, digit3, dig_mask, blink_mask,
    output com, seg, scan_idx, frame_done
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scanner with blank gaps between slots,
// per-digit enable masking and per-digit blinking. All outputs are registered.
module fnd_scan_ctrl #(
  parameter int unsigned ON_CYC    = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned BLINK_CYC = 25000000
) (
  input logic       clk,
  input logic       rst,
  fnd_scan_if.slave bus_io
);

  localparam int unsigned SlotMax = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int unsigned SlotW   = (SlotMax > 1) ? $clog2(SlotMax) : 1;
  localparam int unsigned BlinkW  = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [SlotW-1:0]  OnLast    = SlotW'(ON_CYC - 1);
  localparam logic [SlotW-1:0]  BlankLast = SlotW'(BLANK_CYC - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYC - 1);

  localparam logic [3:0] ComOff = 4'hF;
  localparam logic [6:0] SegOff = 7'h7F;

  typedef enum logic [1:0] {StIdle, StOn, StBlank} state_e;

  state_e              state_q;
  logic [SlotW-1:0]    slot_cnt_q;
  logic [BlinkW-1:0]   blink_cnt_q;
  logic                blink_phase_q;
  logic [3:0]          com_q;
  logic [6:0]          seg_q;
  logic [1:0]          scan_idx_q;
  logic                frame_done_q;

  logic [1:0] first_idx;
  logic [1:0] next_idx;
  logic [1:0] ent_idx;
  logic [3:0] ent_code;
  logic [3:0] ent_com;
  logic [6:0] ent_seg;
  logic       next_wraps;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hB:    return 7'h09;
      default: return 7'h7F;
    endcase
  endfunction

  // Lowest enabled digit (restart point) and next enabled digit after the
  // current one, wrapping; the current digit itself is the last candidate.
  always_comb begin
    first_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus_io.dig_mask[2'(i)]) first_idx = 2'(i);
    end
    next_idx = scan_idx_q;
    for (int k = 4; k >= 1; k--) begin
      if (bus_io.dig_mask[scan_idx_q + 2'(k)]) next_idx = scan_idx_q + 2'(k);
    end
  end

  assign next_wraps = (next_idx <= scan_idx_q);
  assign ent_idx    = (state_q == StIdle) ? first_idx : next_idx;

  always_comb begin
    ent_code = bus_io.digit0;
    unique case (ent_idx)
      2'd0: ent_code = bus_io.digit0;
      2'd1: ent_code = bus_io.digit1;
      2'd2: ent_code = bus_io.digit2;
      2'd3: ent_code = bus_io.digit3;
    endcase
  end

  // Blinked-off digits keep their common line active but show no segments.
  assign ent_com = ~(4'b0001 << ent_idx);
  assign ent_seg = (bus_io.blink_mask[ent_idx] && blink_phase_q) ? SegOff
                                                                 : seg_decode(ent_code);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      slot_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      com_q         <= ComOff;
      seg_q         <= SegOff;
      scan_idx_q    <= 2'd0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if (bus_io.en) begin
        if (blink_cnt_q == BlinkLast) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BlinkW'(1);
        end
      end

      if (!bus_io.en) begin
        state_q    <= StIdle;
        slot_cnt_q <= '0;
        com_q      <= ComOff;
        seg_q      <= SegOff;
      end else begin
        case (state_q)
          StIdle: begin
            com_q <= ComOff;
            seg_q <= SegOff;
            if (bus_io.dig_mask != 4'd0) begin
              state_q    <= StOn;
              slot_cnt_q <= '0;
              scan_idx_q <= first_idx;
              com_q      <= ent_com;
              seg_q      <= ent_seg;
            end
          end
          StOn: begin
            if (slot_cnt_q == OnLast) begin
              state_q    <= StBlank;
              slot_cnt_q <= '0;
              com_q      <= ComOff;
              seg_q      <= SegOff;
            end else begin
              slot_cnt_q <= slot_cnt_q + SlotW'(1);
            end
          end
          StBlank: begin
            if (slot_cnt_q == BlankLast) begin
              slot_cnt_q <= '0;
              if (bus_io.dig_mask == 4'd0) begin
                state_q <= StIdle;
              end else begin
                state_q      <= StOn;
                scan_idx_q   <= next_idx;
                com_q        <= ent_com;
                seg_q        <= ent_seg;
                frame_done_q <= next_wraps;
              end
            end else begin
              slot_cnt_q <= slot_cnt_q + SlotW'(1);
            end
          end
          default: begin
            state_q    <= StIdle;
            slot_cnt_q <= '0;
            com_q      <= ComOff;
            seg_q      <= SegOff;
          end
        endcase
      end
    end
  end

  assign bus_io.com        = com_q;
  assign bus_io.seg        = seg_q;
  assign bus_io.scan_idx   = scan_idx_q;
  assign bus_io.frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with ON_CYC=4, BLANK_CYC=2, BLINK_CYC=32.
// Comments give t = edges since the first edge with rst low.
module tb_fnd_scan_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fnd_scan_if bus ();

  fnd_scan_ctrl #(
    .ON_CYC   (4),
    .BLANK_CYC(2),
    .BLINK_CYC(32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] c, input logic [6:0] s,
                     input logic [1:0] i, input logic f);
    total++;
    assert ({bus.com, bus.seg, bus.scan_idx, bus.frame_done} === {c, s, i, f}) else begin
      bad++;
      $error("FAIL %s: got com=%h seg=%h idx=%0d fd=%b, want com=%h seg=%h idx=%0d fd=%b",
             tag, bus.com, bus.seg, bus.scan_idx, bus.frame_done, c, s, i, f);
    end
  endtask

  // One ON slot of 4 cycles followed by 2 blank cycles.
  task automatic run_slot(input string tag, input logic [1:0] idx, input logic [6:0] s,
                          input logic fd);
    logic [3:0] c;
    c = ~(4'b0001 << idx);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk(tag, c, s, idx, (n == 0) ? fd : 1'b0);
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      chk({tag, "_blank"}, 4'hF, 7'h7F, idx, 1'b0);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    bus.en         = 1'b1;
    bus.digit0     = 4'h6;
    bus.digit1     = 4'h2;
    bus.digit2     = 4'h0;
    bus.digit3     = 4'hB;
    bus.dig_mask   = 4'hF;
    bus.blink_mask = 4'h0;

    for (int n = 0; n < 3; n++) begin
      tick();
      chk("reset_hold", 4'hF, 7'h7F, 2'd0, 1'b0);
    end
    rst = 1'b0;

    // Full 4-digit rounds, t=1..48; frame_done only after a wrap.
    for (int r = 0; r < 2; r++) begin
      run_slot("full_d0", 2'd0, 7'h02, (r == 1));
      run_slot("full_d1", 2'd1, 7'h24, 1'b0);
      run_slot("full_d2", 2'd2, 7'h40, 1'b0);
      run_slot("full_d3", 2'd3, 7'h09, 1'b0);
    end

    // Digits 0 and 2 only, t=49..72: 12-cycle period.
    bus.dig_mask = 4'b0101;
    for (int r = 0; r < 2; r++) begin
      run_slot("mask_d0", 2'd0, 7'h02, 1'b1);
      run_slot("mask_d2", 2'd2, 7'h40, 1'b0);
    end

    // Blink digit 3: phase 0 at entry t=73, phase 1 at entry t=97.
    bus.blink_mask = 4'b1000;
    bus.dig_mask   = 4'hF;
    run_slot("blink_d3_vis", 2'd3, 7'h09, 1'b0);
    run_slot("blink_d0", 2'd0, 7'h02, 1'b1);
    run_slot("blink_d1", 2'd1, 7'h24, 1'b0);
    run_slot("blink_d2", 2'd2, 7'h40, 1'b0);
    run_slot("blink_d3_off", 2'd3, 7'h7F, 1'b0);
    run_slot("blink_d0b", 2'd0, 7'h02, 1'b1);

    // Drop en in the second cycle of the digit-1 slot.
    tick();
    chk("en_d1_c1", 4'hD, 7'h24, 2'd1, 1'b0);
    tick();
    chk("en_d1_c2", 4'hD, 7'h24, 2'd1, 1'b0);
    bus.en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("en_low_idle", 4'hF, 7'h7F, 2'd1, 1'b0);
    end
    bus.en = 1'b1;
    run_slot("reen_d0", 2'd0, 7'h02, 1'b0);
    run_slot("reen_d1", 2'd1, 7'h24, 1'b0);

    // Clear dig_mask during the digit-2 slot: slot and blank finish, then idle.
    for (int n = 0; n < 2; n++) begin
      tick();
      chk("mask0_d2_pre", 4'hB, 7'h40, 2'd2, 1'b0);
    end
    bus.dig_mask = 4'h0;
    for (int n = 0; n < 2; n++) begin
      tick();
      chk("mask0_d2_post", 4'hB, 7'h40, 2'd2, 1'b0);
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      chk("mask0_blank", 4'hF, 7'h7F, 2'd2, 1'b0);
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      chk("mask0_idle", 4'hF, 7'h7F, 2'd2, 1'b0);
    end
    bus.dig_mask = 4'hF;
    run_slot("remask_d0", 2'd0, 7'h02, 1'b0);

    // Reset during the digit-1 blank gap.
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("rstb_d1", 4'hD, 7'h24, 2'd1, 1'b0);
    end
    tick();
    chk("rstb_blank", 4'hF, 7'h7F, 2'd1, 1'b0);
    rst = 1'b1;
    tick();
    chk("rstb_reset", 4'hF, 7'h7F, 2'd0, 1'b0);
    rst        = 1'b0;
    bus.digit1 = 4'hA;
    bus.digit2 = 4'h7;
    run_slot("post_d0", 2'd0, 7'h02, 1'b0);
    run_slot("post_d1_blankcode", 2'd1, 7'h7F, 1'b0);
    run_slot("post_d2_seven", 2'd2, 7'h78, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
